uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a first-word-fall-through output FIFO and error reporting. It is the next-generation receive front end for the UART-driven matrix-vector systems, replacing the fixed 8N1 receiver. It generalises word width, bit period and buffer depth, and adds the following over the old front end:
- start-bit glitch rejection
- framing, overflow and (optionally) parity detection
- valid/ready backpressure toward the MVM input loader

---
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, framing/overflow flags and a FWFT output FIFO.
// Defining UART_RX_PARITY_EN adds a parity bit per frame, the parity_odd/parity_err ports and bad-word dropping.
module uart_rx_fifo #(
    parameter int CLOCKS_PER_PULSE = 33,
    parameter int BITS_PER_WORD    = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             rx,
    output logic [BITS_PER_WORD-1:0]         m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             frame_err,
    output logic                             overflow,
    input  logic                             clr_err
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                             parity_odd,
    output logic                             parity_err
`endif
);
    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W = $clog2(BITS_PER_WORD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] WORD_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    state_t state, state_next;

    logic                     rx_meta, rx_s;
    logic [CNT_W-1:0]         cnt;
    logic [BIT_W-1:0]         bit_idx;
    logic [BITS_PER_WORD-1:0] shreg;
    logic                     cnt_run, sample, shift_en, push, frame_set;
    logic [BITS_PER_WORD-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic                     pop, full, push_ok, ovf_set;
`ifdef UART_RX_PARITY_EN
    logic                     bad, par_check, par_set;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (sample) state_next = rx_s ? IDLE : DATA;
            DATA:      if (sample && bit_idx == WORD_LAST)
`ifdef UART_RX_PARITY_EN
                           state_next = PARITY;
            PARITY:    if (sample) state_next = STOP;
`else
                           state_next = STOP;
`endif
            STOP:      if (sample) state_next = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // START samples at mid-bit; later states sample at the end of each bit period.
    always_comb begin
        cnt_run   = 1'b0;
        sample    = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_check = 1'b0;
`endif
        case (state)
            START: begin
                cnt_run = 1'b1;
                sample  = (cnt == HALF_LAST);
            end
            DATA: begin
                cnt_run  = 1'b1;
                sample   = (cnt == PULSE_LAST);
                shift_en = sample;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_run   = 1'b1;
                sample    = (cnt == PULSE_LAST);
                par_check = sample;
            end
`endif
            STOP: begin
                cnt_run   = 1'b1;
                sample    = (cnt == PULSE_LAST);
`ifdef UART_RX_PARITY_EN
                push      = sample && rx_s && !bad;
`else
                push      = sample && rx_s;
`endif
                frame_set = sample && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if (!cnt_run || sample) cnt <= '0;
            else                    cnt <= cnt + 1'b1;
            if (state != DATA)      bit_idx <= '0;
            else if (sample)        bit_idx <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[BITS_PER_WORD-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    assign par_set = par_check && ((^shreg ^ rx_s) != parity_odd);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bad        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == START) bad <= 1'b0;
            else if (par_set)   bad <= 1'b1;
            if (par_set)        parity_err <= 1'b1;
            else if (clr_err)   parity_err <= 1'b0;
        end
    end
`endif

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign pop     = m_valid && m_ready;
    assign full    = (fifo_count == FULL_COUNT);
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at default parameters (8 data bits, 33 clk/bit, depth 4).
module tb_uart_rx_fifo;
    localparam int CPP = 33;
    localparam int BPW = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
    localparam int STOP_EDGE = 349;
`else
    localparam int STOP_EDGE = 316;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           rx = 1'b1;
    logic [BPW-1:0] m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [CW-1:0]  fifo_count;
    logic           frame_err, overflow;
    logic           clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic           parity_odd = 1'b0;
    logic           parity_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [BPW-1:0] exp_q[$];
    logic [BPW-1:0] exp_word;

    uart_rx_fifo #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .rx(rx), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_count(fifo_count), .frame_err(frame_err),
        .overflow(overflow), .clr_err(clr_err)
`ifdef UART_RX_PARITY_EN
        , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %0h, required no word", m_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (m_data !== exp_word) begin
                    fails++;
                    $display("FAIL pop_data: got %0h, required %0h", m_data, exp_word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [BPW-1:0] d, input logic stop_b, input logic par_b);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < BPW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`else
        if (par_b === 1'bx) drive_bit(1'b1);
`endif
        drive_bit(stop_b);
    endtask

    task automatic send_frame(input logic [BPW-1:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
        send_raw(d, stop_b, (^d) ^ parity_odd);
`else
        send_raw(d, stop_b, 1'b0);
`endif
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1 m_ready = 1'b0;
        check({name, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_count"}, fifo_count, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", m_data, 0);
        check("rst_flags", {frame_err, overflow}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);

        // single word, push latency from frame start
        n = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                #1;
                while (!m_valid && n < 500) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("a5_latency", n, STOP_EDGE + 1);
        @(negedge clk);
        check("a5_data", m_data, 8'hA5);
        check("a5_count", fifo_count, 1);
        check("a5_flags", {frame_err, overflow}, 0);
        exp_q.push_back(8'hA5);
        drain("a5_drain");

        // overflow: fifth word dropped
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        @(negedge clk);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", m_data, 8'h01);
        pulse_clr();
        check("ovf_clr", overflow, 0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        drain("ovf_drain");

        // full FIFO with a pop in the push cycle
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        fork
            send_frame(8'h05, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1 m_ready = 1'b1;
                @(posedge clk);
                #1 m_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("fullpop_count", fifo_count, 4);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_head", m_data, 8'h02);
        drain("fullpop_drain");

        // start-bit glitch, then a good frame received with m_ready held high
        m_ready = 1'b1;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("glitch_count", fifo_count, 0);
        check("glitch_flags", {frame_err, overflow}, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        check("3c_left", exp_q.size(), 0);
        check("3c_count", fifo_count, 0);

        // framing error followed by a long break
        send_frame(8'h55, 1'b0);
        repeat (200) @(posedge clk);
        #1 rx = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("ferr_flag", frame_err, 1);
        check("ferr_count", fifo_count, 0);
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(negedge clk);
        check("ferr_hold", frame_err, 1);
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        check("ferr_clr", frame_err, 0);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_raw(8'h07, 1'b1, 1'b0);
        @(negedge clk);
        check("par_err", parity_err, 1);
        check("par_bad_count", fifo_count, 0);
        send_raw(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        check("par_ok_count", fifo_count, 1);
        check("par_ok_data", m_data, 8'h07);
        pulse_clr();
        check("par_clr", parity_err, 0);
        exp_q.push_back(8'h07);
        drain("par_drain");
`endif

        // asynchronous reset mid-frame with data held and a flag set
        send_frame(8'h11, 1'b1);
        send_frame(8'h12, 1'b0);
        #1 rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_count", fifo_count, 1);
        check("pre_rst_ferr", frame_err, 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (150) @(posedge clk);
                #3 rstn = 1'b0;
                #1;
                check("mid_rst_valid", m_valid, 0);
                check("mid_rst_count", fifo_count, 0);
                check("mid_rst_data", m_data, 0);
                check("mid_rst_flags", {frame_err, overflow}, 0);
                @(posedge clk);
                #2 rstn = 1'b1;
            end
        join
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("post_rst_count", fifo_count, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
